// File: rtl/r4_booth_mul_pipe_if.sv
// Operand/result handshake bundle for r4_booth_mul_pipe.
// The redundant out_sum/out_carry pair exists only when R4M_SC_OUT_EN is defined.
interface r4_booth_mul_pipe_if #(
  parameter int WIDTH = 11,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_mx;
  logic [WIDTH-1:0]   in_my;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic               out_zero;
  logic [TAG_W-1:0]   out_tag;
`ifdef R4M_SC_OUT_EN
  logic [2*WIDTH-1:0] out_sum;
  logic [2*WIDTH-1:0] out_carry;

  modport master (
    output in_valid, in_signed, in_mx, in_my, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_zero, out_tag, out_sum, out_carry
  );
  modport slave (
    input  in_valid, in_signed, in_mx, in_my, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_zero, out_tag, out_sum, out_carry
  );
`else
  modport master (
    output in_valid, in_signed, in_mx, in_my, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_zero, out_tag
  );
  modport slave (
    input  in_valid, in_signed, in_mx, in_my, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_zero, out_tag
  );
`endif
endinterface

// File: rtl/r4_booth_mul_pipe.sv
// 3-stage radix-4 Booth multiplier (encode / carry-save reduce / CPA) with elastic valid/ready.
// Define R4M_SC_OUT_EN to also register the redundant sum/carry pair onto out_sum/out_carry.
module r4_booth_mul_pipe #(
  parameter int WIDTH = 11,
  parameter int TAG_W = 4
) (
  input logic                CLK,
  input logic                RST,
  r4_booth_mul_pipe_if.slave bus
);
  localparam int G   = (WIDTH + 2) / 2;
  localparam int PPW = WIDTH + 3;
  localparam int NW  = 2 * WIDTH;
  localparam int XW  = 2 * G + 1;

  // Returns {neg, pp}. Row 0 is the raw PP sign-extended by one bit (its top ~e is added
  // during reduction); other rows carry {1, ~e}, so all sign-extension constants cancel mod 2^NW.
  function automatic logic [PPW:0] booth_pp(input logic [2:0] trip,
                                            input logic signed [WIDTH+1:0] y,
                                            input logic first);
    logic             mag1;
    logic             mag2;
    logic             neg;
    logic             e;
    logic [WIDTH+1:0] sel;
    logic [WIDTH+1:0] pp;
    mag1 = trip[0] ^ trip[1];
    mag2 = (trip == 3'b011) | (trip == 3'b100);
    neg  = trip[2] & ~(trip[1] & trip[0]);
    sel  = mag1 ? y : (mag2 ? (y <<< 1) : '0);
    pp   = neg ? ~sel : sel;
    e    = pp[WIDTH+1];
    booth_pp = first ? {neg, e, pp} : {neg, 1'b1, ~e, pp[WIDTH:0]};
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic rdy_p1, rdy_p2, rdy_p3;

  assign rdy_p3       = ~vld_p3 | bus.out_ready;
  assign rdy_p2       = ~vld_p2 | rdy_p3;
  assign rdy_p1       = ~vld_p1 | rdy_p2;
  assign bus.in_ready = rdy_p1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (rdy_p1) vld_p1 <= bus.in_valid;
      if (rdy_p2) vld_p2 <= vld_p1;
      if (rdy_p3) vld_p3 <= vld_p2;
    end
  end

  // ---- stage 1: operand extension and Booth encode ----
  logic                    ext_x;
  logic                    ext_y;
  logic [XW-1:0]           xp;
  logic signed [WIDTH+1:0] ye;
  logic [PPW-1:0]          pp_d [G];
  logic [G-1:0]            neg_d;

  assign ext_x = bus.in_signed & bus.in_mx[WIDTH-1];
  assign ext_y = bus.in_signed & bus.in_my[WIDTH-1];
  assign xp    = {{(XW-WIDTH-1){ext_x}}, bus.in_mx, 1'b0};
  assign ye    = {{2{ext_y}}, bus.in_my};

  always_comb begin
    for (int j = 0; j < G; j++) begin
      {neg_d[j], pp_d[j]} = booth_pp(xp[2*j +: 3], ye, j == 0);
    end
  end

  logic [PPW-1:0]   pp_p1 [G];
  logic [G-1:0]     neg_p1;
  logic [TAG_W-1:0] tag_p1;

  // ---- stage 2: carry-save reduction of all rows and neg bits ----
  logic [NW-1:0]    sum_d;
  logic [NW-1:0]    carry_d;
  logic [NW-1:0]    sum_p2;
  logic [NW-1:0]    carry_p2;
  logic [TAG_W-1:0] tag_p2;

  always_comb begin
    logic [NW-1:0] s;
    logic [NW-1:0] c;
    logic [NW-1:0] a;
    logic [NW-1:0] maj;
    s = NW'({~pp_p1[0][PPW-1], pp_p1[0]});
    c = '0;
    for (int j = 0; j < G; j++) begin
      c[2*j] = neg_p1[j];
    end
    for (int j = 1; j < G; j++) begin
      a   = NW'(pp_p1[j]) << (2 * j);
      maj = (s & c) | (s & a) | (c & a);
      s   = s ^ c ^ a;
      c   = maj << 1;
    end
    sum_d   = s;
    carry_d = c;
  end

  always_ff @(posedge CLK) begin
    if (rdy_p1) begin
      pp_p1  <= pp_d;
      neg_p1 <= neg_d;
      tag_p1 <= bus.in_tag;
    end
    if (rdy_p2) begin
      sum_p2   <= sum_d;
      carry_p2 <= carry_d;
      tag_p2   <= tag_p1;
    end
  end

  // ---- stage 3: carry-propagate add onto the output registers ----
  logic [NW-1:0]    prod_d;
  logic [NW-1:0]    prod_p3;
  logic             zero_p3;
  logic [TAG_W-1:0] tag_p3;

  assign prod_d = sum_p2 + carry_p2;

`ifdef R4M_SC_OUT_EN
  logic [NW-1:0] sum_p3;
  logic [NW-1:0] carry_p3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_p3   <= '0;
      carry_p3 <= '0;
    end else if (rdy_p3) begin
      sum_p3   <= sum_p2;
      carry_p3 <= carry_p2;
    end
  end

  assign bus.out_sum   = sum_p3;
  assign bus.out_carry = carry_p3;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prod_p3 <= '0;
      zero_p3 <= 1'b0;
      tag_p3  <= '0;
    end else if (rdy_p3) begin
      prod_p3 <= prod_d;
      zero_p3 <= (prod_d == '0);
      tag_p3  <= tag_p2;
    end
  end

  assign bus.out_valid = vld_p3;
  assign bus.out_prod  = prod_p3;
  assign bus.out_zero  = zero_p3;
  assign bus.out_tag   = tag_p3;
endmodule

// File: tb/tb_r4_booth_mul_pipe.sv
// Self-checking bench for r4_booth_mul_pipe: integer-arithmetic product model with an
// in-order expectation queue, checked every cycle, plus literal products for known operands.
module tb_r4_booth_mul_pipe;
  localparam int W  = 11;
  localparam int TW = 4;
  localparam int PW = 2 * W;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  r4_booth_mul_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  r4_booth_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  typedef struct {
    logic [PW-1:0] prod;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_acc = 0;
  int            n_emit = 0;
  bit            strict_lat = 1'b1;
  bit            acc_now = 1'b0;
  bit            held_v = 1'b0;
  logic [PW-1:0] held_prod = '0;
  logic [PW-1:0] last_prod = '0;
  logic [TW-1:0] held_tag = '0;
  logic [TW-1:0] last_tag = '0;
  logic          held_zero = 1'b0;
  logic          last_zero = 1'b0;
  logic          s_tab  [8];
  logic [W-1:0]  mx_tab [8];
  logic [W-1:0]  my_tab [8];

  function automatic logic [PW-1:0] model(input logic s, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint x;
    longint y;
    longint p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[PW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic mon();
    exp_t e;
`ifdef R4M_SC_OUT_EN
    logic [PW-1:0] sc;
`endif
    acc_now = 1'b0;
    if (RST) begin
      q.delete();
      held_v = 1'b0;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_prod", 64'(bus.out_prod), 64'd0);
      chk("rst_out_zero", 64'(bus.out_zero), 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
`ifdef R4M_SC_OUT_EN
      chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
      chk("rst_out_carry", 64'(bus.out_carry), 64'd0);
`endif
    end else begin
      if (held_v) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_prod", 64'(bus.out_prod), 64'(held_prod));
        chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
        chk("hold_zero", 64'(bus.out_zero), 64'(held_zero));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got prod 0x%0h tag %0d, expected no result (cycle %0d)",
                   bus.out_prod, bus.out_tag, cyc);
        end else begin
          e = q.pop_front();
          chk("prod", 64'(bus.out_prod), 64'(e.prod));
          chk("tag", 64'(bus.out_tag), 64'(e.tag));
          chk("zero", 64'(bus.out_zero), 64'(e.prod == '0));
          if (strict_lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
`ifdef R4M_SC_OUT_EN
          sc = bus.out_sum + bus.out_carry;
          chk("sc_pair", 64'(sc), 64'(e.prod));
`endif
        end
        last_prod = bus.out_prod;
        last_tag  = bus.out_tag;
        last_zero = bus.out_zero;
        n_emit++;
      end
      held_v    = bus.out_valid && !bus.out_ready;
      held_prod = bus.out_prod;
      held_tag  = bus.out_tag;
      held_zero = bus.out_zero;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{prod: model(bus.in_signed, bus.in_mx, bus.in_my), tag: bus.in_tag, cyc: cyc});
        n_acc++;
        acc_now = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    mon();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t);
    int k;
    k = 0;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.in_mx     = a;
    bus.in_my     = b;
    bus.in_tag    = t;
    do begin
      tick();
      k++;
    end while (!acc_now && k < 50);
    bus.in_valid = 1'b0;
    if (!acc_now) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", k);
    end
  endtask

  task automatic run_lit(input string name, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] t,
                         input logic [PW-1:0] want);
    int e0;
    int k;
    e0 = n_emit;
    k  = 0;
    chk({name, "_model"}, 64'(model(s, a, b)), 64'(want));
    send(s, a, b, t);
    while (n_emit == e0 && k < 10) begin
      tick();
      k++;
    end
    chk({name, "_emitted"}, 64'(n_emit - e0), 64'd1);
    chk({name, "_prod"}, 64'(last_prod), 64'(want));
    chk({name, "_tag"}, 64'(last_tag), 64'(t));
    chk({name, "_zero"}, 64'(last_zero), 64'(want == '0));
  endtask

  // mode 0: directed table, out_ready high; 1: random data, out_ready low for 6 cycles;
  // 2: random data, random in_valid bubbles and random out_ready.
  task automatic stream(input int n, input int mode);
    int idx;
    int gen;
    int k;
    int a0;
    idx = 0;
    gen = -1;
    k   = 0;
    a0  = n_acc;
    while (idx < n && k < 20000) begin
      if (mode == 1 && k == 6) begin
        chk("stall_accepts", 64'(n_acc - a0), 64'd3);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      end
      if (mode == 0)      bus.out_ready = 1'b1;
      else if (mode == 1) bus.out_ready = (k >= 6);
      else                bus.out_ready = 1'($urandom_range(0, 1));
      if (idx != gen) begin
        gen = idx;
        if (mode == 0) begin
          bus.in_signed = s_tab[idx];
          bus.in_mx     = mx_tab[idx];
          bus.in_my     = my_tab[idx];
        end else begin
          bus.in_signed = 1'($urandom);
          bus.in_mx     = W'($urandom);
          bus.in_my     = W'($urandom);
          if (idx % 16 == 3) bus.in_mx = '0;
          if (idx % 16 == 9) bus.in_my = '0;
        end
        bus.in_tag = TW'(idx);
      end
      bus.in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (acc_now) idx++;
      k++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (mode == 0) chk("stream_cycles", 64'(k), 64'(n));
    k = 0;
    while (q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int e0;
    s_tab  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    mx_tab = '{11'h7FB, 11'h7FF, 11'h400, 11'h155, 11'h3FF, 11'h000, 11'h001, 11'h400};
    my_tab = '{11'h003, 11'h001, 11'h7FF, 11'h2AA, 11'h400, 11'h7FF, 11'h001, 11'h400};
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_mx     = '0;
    bus.in_my     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    RST = 1'b0;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);

    run_lit("s_3_x_m5", 1'b1, 11'h003, 11'h7FB, 4'h5, 22'h3FFFF1);
    run_lit("s_min_sq", 1'b1, 11'h400, 11'h400, 4'h6, 22'h100000);
    run_lit("u_max_sq", 1'b0, 11'h7FF, 11'h7FF, 4'h7, 22'h3FF001);
    run_lit("s_m1_x_1", 1'b1, 11'h7FF, 11'h001, 4'h8, 22'h3FFFFF);
    run_lit("u_1024_sq", 1'b0, 11'h400, 11'h400, 4'h9, 22'h100000);
    run_lit("s_1023_sq", 1'b1, 11'h3FF, 11'h3FF, 4'hA, 22'h0FF801);
    run_lit("u_zero_x", 1'b0, 11'h000, 11'h5A5, 4'hB, 22'h000000);
    run_lit("s_zero_y", 1'b1, 11'h123, 11'h000, 4'hC, 22'h000000);

    stream(8, 0);

    strict_lat = 1'b0;
    stream(10, 1);

    e0 = n_emit;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_signed = 1'b1;
      bus.in_mx     = W'(i + 5);
      bus.in_my     = 11'h7F0;
      bus.in_tag    = TW'(i + 1);
      tick();
      chk("rst_fill_accept", 64'(acc_now), 64'd1);
    end
    bus.in_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_async_prod", 64'(bus.out_prod), 64'd0);
    tick();
    RST = 1'b0;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("post_rst_emits", 64'(n_emit - e0), 64'd0);

    stream(1000, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
